// File: rtl/bridge_wr_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bridge_wr_fifo_pkg
// Description : Shared types and constants for the bridge write FIFO slave.
//               Holds the bridge address/data types, the register offset map
//               (DATA/STATUS/CTRL) and the STATUS/CTRL bit positions.
//               Optional feature macro used by this block:
//               BRIDGE_WR_FIFO_BYTESWAP_EN (byte-reverse DATA writes).
// Revision    : 1.0 - initial release
// ============================================================================
package bridge_wr_fifo_pkg;

    typedef logic [31:0] bridge_addr_t;
    typedef logic [31:0] bridge_data_t;

    // Register offsets within the 16-byte window (word index = addr[3:2])
    localparam logic [1:0] BRIDGE_WR_FIFO_OFF_DATA   = 2'd0;
    localparam logic [1:0] BRIDGE_WR_FIFO_OFF_STATUS = 2'd1;
    localparam logic [1:0] BRIDGE_WR_FIFO_OFF_CTRL   = 2'd2;
    localparam logic [1:0] BRIDGE_WR_FIFO_OFF_RSVD   = 2'd3;

    // STATUS word bit positions; level occupies [15:0]
    localparam int BRIDGE_WR_FIFO_STATUS_OVF   = 31;
    localparam int BRIDGE_WR_FIFO_STATUS_FULL  = 30;
    localparam int BRIDGE_WR_FIFO_STATUS_EMPTY = 29;

    // CTRL word bit positions
    localparam int BRIDGE_WR_FIFO_CTRL_FLUSH   = 0;
    localparam int BRIDGE_WR_FIFO_CTRL_CLR_OVF = 1;

    // Reverse byte order: APF big-endian word to core byte order
    function automatic bridge_data_t bridge_wr_fifo_byteswap(input bridge_data_t d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bridge_wr_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : bridge_if
// Description : APF bridge bus bundle. The master drives addr/wr_data/wr/rd;
//               the slave returns rd_data (registered, ORable across slaves).
//   addr     32  byte address
//   wr_data  32  write data, valid with wr
//   wr        1  one-cycle write strobe
//   rd        1  one-cycle read strobe
//   rd_data  32  read data, valid the cycle after rd
// Revision    : 1.0 - initial release
// ============================================================================
interface bridge_if;
    import bridge_wr_fifo_pkg::*;

    bridge_addr_t addr;
    bridge_data_t wr_data;
    logic         wr;
    logic         rd;
    bridge_data_t rd_data;

    modport master (
        output addr,
        output wr_data,
        output wr,
        output rd,
        input  rd_data
    );

    modport slave (
        input  addr,
        input  wr_data,
        input  wr,
        input  rd,
        output rd_data
    );

endinterface
`default_nettype wire

// File: rtl/bridge_wr_fifo_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync
// Description : Single-clock FIFO with push/pop/flush and occupancy level.
//   clk        in   1          clock, rising edge
//   reset_n    in   1          synchronous active-low reset
//   i_push     in   1          write request (dropped when full unless popping)
//   i_pop      in   1          read request (ignored when empty)
//   i_flush    in   1          empty the FIFO; overrides push and pop
//   i_data     in   WIDTH      write data
//   o_data     out  WIDTH      head word (valid when !o_empty)
//   o_full     out  1          level == DEPTH
//   o_empty    out  1          level == 0
//   o_level    out  LVL_W      occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  wire logic                       clk,
    input  wire logic                       reset_n,
    input  wire logic                       i_push,
    input  wire logic                       i_pop,
    input  wire logic                       i_flush,
    input  wire logic [WIDTH-1:0]           i_data,
    output logic      [WIDTH-1:0]           o_data,
    output logic                            o_full,
    output logic                            o_empty,
    output logic      [$clog2(DEPTH):0]     o_level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_LVL_W-1:0] level_q,  level_d;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full  = (level_q == c_LVL_W'(DEPTH));
    assign o_empty = (level_q == '0);
    assign o_level = level_q;
    assign o_data  = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // push when it is also being popped.
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop_ok) begin
                rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
            end
            level_d = level_q + c_LVL_W'(w_push_ok) - c_LVL_W'(w_pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: pointers and level define which words are live.
    always_ff @(posedge clk) begin
        if (reset_n && w_push_ok && !i_flush) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bridge_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bridge_wr_fifo
// Description : Bridge slave that buffers DATA-register writes in a FIFO and
//               streams them to core logic over valid/ready. STATUS reports
//               level/full/empty/overflow; CTRL flushes and clears overflow.
//   clk        in   1          bridge clock
//   reset_n    in   1          synchronous active-low reset
//   bridge     if   bridge_if  slave side of the bridge bus
//   out_data   out  32         FIFO head word
//   out_valid  out  1          FIFO non-empty
//   out_ready  in   1          consumer accepts head when valid && ready
//   overflow   out  1          sticky: a DATA write was dropped (FIFO full)
// Register map (word offset addr[3:2]):
//   0 DATA (W)  1 STATUS (R)  2 CTRL (W: bit0 flush, bit1 clear ovf)  3 rsvd
// Build option: BRIDGE_WR_FIFO_BYTESWAP_EN byte-reverses DATA writes.
// Revision    : 1.0 - initial release
// ============================================================================
module bridge_wr_fifo
    import bridge_wr_fifo_pkg::*;
#(
    parameter bridge_addr_t ADDR_BASE = 32'h0000_0000,
    parameter bridge_addr_t ADDR_MASK = 32'hFFFF_FFF0,
    parameter int           DEPTH     = 16
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    bridge_if.slave     bridge,
    output bridge_data_t out_data,
    output logic        out_valid,
    input  wire logic   out_ready,
    output logic        overflow
);

    localparam int c_LVL_W = $clog2(DEPTH) + 1;

    logic               w_hit;
    logic [1:0]         w_off;
    logic               w_push;
    logic               w_ctrl_wr;
    logic               w_flush;
    logic               w_clr_ovf;
    logic               w_drop;
    bridge_data_t       w_push_data;
    bridge_data_t       w_status;
    bridge_data_t       w_rd_mux;

    logic               w_full;
    logic               w_empty;
    logic [c_LVL_W-1:0] w_level;

    logic               overflow_q, overflow_d;
    bridge_data_t       rd_data_q,  rd_data_d;

    // ---------------------------------------------------------------- decode
    assign w_hit     = ((bridge.addr & ADDR_MASK) == ADDR_BASE);
    assign w_off     = bridge.addr[3:2];
    assign w_push    = bridge.wr && w_hit && (w_off == BRIDGE_WR_FIFO_OFF_DATA);
    assign w_ctrl_wr = bridge.wr && w_hit && (w_off == BRIDGE_WR_FIFO_OFF_CTRL);
    assign w_flush   = w_ctrl_wr && bridge.wr_data[BRIDGE_WR_FIFO_CTRL_FLUSH];
    assign w_clr_ovf = w_ctrl_wr && bridge.wr_data[BRIDGE_WR_FIFO_CTRL_CLR_OVF];

    // A full FIFO only drops the push when the head is not leaving this cycle.
    assign w_drop    = w_push && w_full && !out_ready;

`ifdef BRIDGE_WR_FIFO_BYTESWAP_EN
    assign w_push_data = bridge_wr_fifo_byteswap(bridge.wr_data);
`else
    assign w_push_data = bridge.wr_data;
`endif

    // ------------------------------------------------------------------ FIFO
    fifo_sync #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (out_ready),
        .i_flush (w_flush),
        .i_data  (w_push_data),
        .o_data  (out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign out_valid = !w_empty;
    assign overflow  = overflow_q;

    // -------------------------------------------------------- overflow flag
    // Set has priority over clear so a drop is never lost.
    always_comb begin
        overflow_d = overflow_q;
        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (w_clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // -------------------------------------------------------------- readback
    always_comb begin
        w_status                              = '0;
        w_status[BRIDGE_WR_FIFO_STATUS_OVF]   = overflow_q;
        w_status[BRIDGE_WR_FIFO_STATUS_FULL]  = w_full;
        w_status[BRIDGE_WR_FIFO_STATUS_EMPTY] = w_empty;
        w_status[15:0]                        = 16'(w_level);
    end

    // DATA and CTRL are write-only and read back as zero, as does rsvd.
    always_comb begin
        w_rd_mux = '0;
        if (w_hit && (w_off == BRIDGE_WR_FIFO_OFF_STATUS)) begin
            w_rd_mux = w_status;
        end
    end

    // Misses return zero so upstream can OR the rd_data of all slaves.
    always_comb begin
        rd_data_d = rd_data_q;
        if (bridge.rd) begin
            rd_data_d = w_rd_mux;
        end
    end

    assign bridge.rd_data = rd_data_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            overflow_q <= overflow_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule
`default_nettype wire
